// File: rtl/fp32_ldexp_pipe.sv
// Two-stage FP32 scale-by-2^k with optional negation, flush-to-zero and IEEE special handling.
// Valid/ready on both sides; in_ready is the combinational stage-1 advance term.
module fp32_ldexp_pipe #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int SHIFT_W = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_data,
    input  logic [SHIFT_W-1:0]       in_shift,
    input  logic                     in_neg,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_data,
    output logic [3:0]               out_flags
);

    localparam logic [1:0] CLS_NORM = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    localparam logic signed [EXP_W+1:0] LP_EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EXP_W+1:0] LP_EXP_ZERO = {(EXP_W+2){1'b0}};

    function automatic logic [1:0] classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        logic [1:0] c;
        if (e == {EXP_W{1'b1}}) begin
            c = (m != {MAN_W{1'b0}}) ? CLS_NAN : CLS_INF;
        end else if (e == {EXP_W{1'b0}}) begin
            c = CLS_ZERO;
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

    logic                    r_s1_valid;
    logic                    r_s1_sign;
    logic [1:0]              r_s1_class;
    logic [MAN_W-1:0]        r_s1_man;
    logic signed [EXP_W+1:0] r_s1_sum;

    logic                    r_out_valid;
    logic [EXP_W+MAN_W:0]    r_out_data;
    logic [3:0]              r_out_flags;

    logic                    w_adv1;
    logic                    w_adv2;
    logic [EXP_W-1:0]        w_in_exp;
    logic [MAN_W-1:0]        w_in_man;
    logic signed [EXP_W+1:0] w_in_sum;
    logic [EXP_W+MAN_W:0]    w_res_data;
    logic [3:0]              w_res_flags;

    assign w_adv2   = ~r_out_valid | out_ready;
    assign w_adv1   = ~r_s1_valid | w_adv2;
    assign in_ready = w_adv1;

    assign w_in_exp = in_data[EXP_W+MAN_W-1:MAN_W];
    assign w_in_man = in_data[MAN_W-1:0];
    // Unsigned exponent plus signed k; two guard bits cover -256..510 without wrap.
    assign w_in_sum = $signed({2'b00, w_in_exp})
                    + $signed({{(EXP_W+2-SHIFT_W){in_shift[SHIFT_W-1]}}, in_shift});

    // Stage 1: capture sign, class, mantissa and biased-exponent sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_class <= CLS_ZERO;
            r_s1_man   <= {MAN_W{1'b0}};
            r_s1_sum   <= LP_EXP_ZERO;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign  <= in_data[EXP_W+MAN_W] ^ in_neg;
                r_s1_class <= classify(w_in_exp, w_in_man);
                r_s1_man   <= w_in_man;
                r_s1_sum   <= w_in_sum;
            end
        end
    end

    // Stage 2 packing: flags are {ovf, unf, nan, inf}.
    always_comb begin
        w_res_data  = {(EXP_W+MAN_W+1){1'b0}};
        w_res_flags = 4'b0000;
        case (r_s1_class)
            CLS_NAN: begin
                w_res_data  = {r_s1_sign, {EXP_W{1'b1}}, r_s1_man};
                w_res_flags = 4'b0010;
            end
            CLS_INF: begin
                w_res_data  = {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                w_res_flags = 4'b0001;
            end
            CLS_ZERO: begin
                w_res_data  = {r_s1_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
                w_res_flags = {1'b0, (r_s1_man != {MAN_W{1'b0}}), 2'b00};
            end
            CLS_NORM: begin
                if (r_s1_sum >= LP_EXP_MAX) begin
                    w_res_data  = {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    w_res_flags = 4'b1001;
                end else if (r_s1_sum <= LP_EXP_ZERO) begin
                    w_res_data  = {r_s1_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
                    w_res_flags = 4'b0100;
                end else begin
                    w_res_data  = {r_s1_sign, r_s1_sum[EXP_W-1:0], r_s1_man};
                    w_res_flags = 4'b0000;
                end
            end
            default: begin
                w_res_data  = {(EXP_W+MAN_W+1){1'b0}};
                w_res_flags = 4'b0000;
            end
        endcase
    end

    // Stage 2 / output register; contents frozen while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {(EXP_W+MAN_W+1){1'b0}};
            r_out_flags <= 4'b0000;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data  <= w_res_data;
                r_out_flags <= w_res_flags;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_flags = r_out_flags;

endmodule
